// File: rtl/bls_serial_sub_ctrl_if.sv
// Request/result and shared-subtractor signals of the serial subtractor sequencer.
// The slave view is the sequencer; the master view is the requester plus the 4-bit subtractor.
interface bls_serial_sub_ctrl_if #(
  parameter int NIBBLES = 4
) ();
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic [3:0]   nib_x;
  logic [3:0]   nib_y;
  logic         nib_bin;
  logic [3:0]   nib_diff;
  logic         nib_bout;

  modport slave (
    input  start, a, b, bin, nib_diff, nib_bout,
    output busy, done, diff, bout, zero, nib_x, nib_y, nib_bin
  );

  modport master (
    output start, a, b, bin, nib_diff, nib_bout,
    input  busy, done, diff, bout, zero, nib_x, nib_y, nib_bin
  );
endinterface

// File: rtl/bls_serial_sub_ctrl.sv
// Multi-precision unsigned subtract A - B - Bin, one nibble per clock through a
// shared external 4-bit borrow-lookahead subtractor, LS nibble first.
module bls_serial_sub_ctrl #(
  parameter int NIBBLES = 4,
  parameter int IDXW    = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  bls_serial_sub_ctrl_if.slave   bus
);
  localparam int W = 4 * NIBBLES;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    diff_work;
  logic [W-1:0]    diff_reg;
  logic [W-1:0]    diff_commit;
  logic            borrow_reg;
  logic            bout_reg;
  logic            zero_reg;
  logic            last;

  assign last        = (idx == IDXW'(NIBBLES - 1));
  // The final nibble comes straight from the subtractor; lower nibbles are already in diff_work.
  assign diff_commit = {bus.nib_diff, diff_work[W-5:0]};

  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
  assign bus.zero = zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.nib_x   = 4'd0;
    bus.nib_y   = 4'd0;
    bus.nib_bin = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        bus.busy    = 1'b1;
        bus.nib_x   = a_reg[{idx, 2'b00} +: 4];
        bus.nib_y   = b_reg[{idx, 2'b00} +: 4];
        bus.nib_bin = borrow_reg;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      diff_work  <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            borrow_reg <= bus.bin;
            idx        <= '0;
          end
        end
        RUN: begin
          diff_work[{idx, 2'b00} +: 4] <= bus.nib_diff;
          borrow_reg                   <= bus.nib_bout;
          // Results are held between operations and only replaced at the last nibble.
          if (last) begin
            diff_reg <= diff_commit;
            bout_reg <= bus.nib_bout;
            zero_reg <= (diff_commit == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bls_serial_sub_ctrl.sv
// Directed bench for bls_serial_sub_ctrl with a behavioural 4-bit subtractor on the nib_* side.
module tb_bls_serial_sub_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bls_serial_sub_ctrl_if #(.NIBBLES(4)) u_if ();

  bls_serial_sub_ctrl #(.NIBBLES(4), .IDXW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  // Combinational 4-bit subtractor: {bout, diff} = x - y - bin
  logic [4:0] sub5;
  always_comb begin
    sub5          = {1'b0, u_if.nib_x} - {1'b0, u_if.nib_y} - {4'd0, u_if.nib_bin};
    u_if.nib_diff = sub5[3:0];
    u_if.nib_bout = sub5[4];
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        z;
    logic        allbin;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Accept one operation and follow it to its done pulse, sampling on falling edges.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                        output int nbusy, output logic [15:0] xseq, output logic allbin,
                        output logic got_done);
    @(negedge clk);
    u_if.start = 1'b1; u_if.a = ia; u_if.b = ib; u_if.bin = ibin;
    @(negedge clk);
    u_if.start = 1'b0;
    nbusy = 0; xseq = '0; allbin = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (u_if.done) break;
      if (u_if.busy) begin
        xseq   = {u_if.nib_x, xseq[15:4]};
        allbin = allbin & u_if.nib_bin;
        nbusy++;
      end
      @(negedge clk);
    end
    got_done = u_if.done;
  endtask

  task automatic wait_done(output logic got_done);
    for (int k = 0; k < 40; k++) begin
      if (u_if.done) break;
      @(negedge clk);
    end
    got_done = u_if.done;
  endtask

  initial begin
    int          nbusy;
    logic [15:0] xseq;
    logic        allbin;
    logic        gd;
    int          ndone;
    int          tdone[$];
    int          extra;

    vecs[0] = '{a:16'hD5C3, b:16'h5A18, bin:1'b0, d:16'h7BAB, bo:1'b0, z:1'b0, allbin:1'b0};
    vecs[1] = '{a:16'h0000, b:16'hFFFF, bin:1'b1, d:16'h0000, bo:1'b1, z:1'b1, allbin:1'b1};
    vecs[2] = '{a:16'h0005, b:16'h0006, bin:1'b0, d:16'hFFFF, bo:1'b1, z:1'b0, allbin:1'b0};
    vecs[3] = '{a:16'h1234, b:16'h1234, bin:1'b0, d:16'h0000, bo:1'b0, z:1'b1, allbin:1'b0};

    u_if.start = 1'b0; u_if.a = '0; u_if.b = '0; u_if.bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(u_if.busy), 0);
    check("reset_done", 32'(u_if.done), 0);
    check("reset_diff", 32'(u_if.diff), 0);
    check("reset_bout", 32'(u_if.bout), 0);
    check("reset_zero", 32'(u_if.zero), 0);
    check("reset_nibx", 32'(u_if.nib_x), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, nbusy, xseq, allbin, gd);
      check($sformatf("v%0d_done", i), 32'(gd), 1);
      check($sformatf("v%0d_busy_cycles", i), 32'(nbusy), 4);
      check($sformatf("v%0d_nibx_seq", i), 32'(xseq), 32'(vecs[i].a));
      check($sformatf("v%0d_nibbin_all", i), 32'(allbin), 32'(vecs[i].allbin));
      check($sformatf("v%0d_diff", i), 32'(u_if.diff), 32'(vecs[i].d));
      check($sformatf("v%0d_bout", i), 32'(u_if.bout), 32'(vecs[i].bo));
      check($sformatf("v%0d_zero", i), 32'(u_if.zero), 32'(vecs[i].z));
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", i), 32'(u_if.done), 0);
      check($sformatf("v%0d_idle_nibx", i), 32'(u_if.nib_x), 0);
    end

    // start pulsed during the 2nd RUN cycle must be ignored
    @(negedge clk);
    u_if.start = 1'b1; u_if.a = 16'hD5C3; u_if.b = 16'h5A18; u_if.bin = 1'b0;
    @(negedge clk);
    u_if.start = 1'b0;
    @(negedge clk);
    u_if.start = 1'b1; u_if.a = 16'h1111; u_if.b = 16'h0000;
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(gd);
    check("ign_done", 32'(gd), 1);
    check("ign_diff", 32'(u_if.diff), 32'h7BAB);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (u_if.done) extra++;
    end
    check("ign_no_extra_done", 32'(extra), 0);

    // Reset asserted in the 3rd RUN cycle
    @(negedge clk);
    u_if.start = 1'b1; u_if.a = 16'h0005; u_if.b = 16'h0006;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_busy_before", 32'(u_if.busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(u_if.busy), 0);
    check("rst_mid_done", 32'(u_if.done), 0);
    check("rst_mid_diff", 32'(u_if.diff), 0);
    check("rst_mid_bout", 32'(u_if.bout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (u_if.done) extra++;
    end
    check("rst_mid_no_done", 32'(extra), 0);
    run_op(16'h8000, 16'h0001, 1'b0, nbusy, xseq, allbin, gd);
    check("rst_after_done", 32'(gd), 1);
    check("rst_after_diff", 32'(u_if.diff), 32'h7FFF);
    check("rst_after_bout", 32'(u_if.bout), 0);

    // Back-to-back with start held high
    @(negedge clk);
    @(negedge clk);
    u_if.start = 1'b1; u_if.a = 16'h1234; u_if.b = 16'h1234; u_if.bin = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (u_if.done) begin
        tdone.push_back(k);
        check($sformatf("b2b_diff_%0d", k), 32'(u_if.diff), 0);
        check($sformatf("b2b_zero_%0d", k), 32'(u_if.zero), 1);
      end
    end
    u_if.start = 1'b0;
    ndone = tdone.size();
    check("b2b_count", 32'(ndone >= 4), 1);
    for (int i = 1; i < ndone; i++)
      check($sformatf("b2b_period_%0d", i), 32'(tdone[i] - tdone[i-1]), 6);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
